// File: rtl/fdiv_pkg.sv
// Shared types and constants for the sequential single-precision divider.
package fdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_e;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int QUOT_W   = 25;
  localparam int REM_W    = MANT_W + 2;

endpackage

// File: rtl/fdiv_restoring_step.sv
// One combinational restoring-division step: subtract the divisor when it fits,
// emit the quotient bit, and shift the partial remainder left by one.
module fdiv_restoring_step
  import fdiv_pkg::*;
(
  input  logic [REM_W-1:0]  rem_i,
  input  logic [MANT_W:0]   mb_i,
  output logic              qbit_o,
  output logic [REM_W-1:0]  rem_o
);

  logic [REM_W-1:0] mb_ext;
  logic [REM_W-1:0] rem_sel;

  assign mb_ext = {1'b0, mb_i};

  always_comb begin
    qbit_o  = (rem_i >= mb_ext);
    rem_sel = qbit_o ? (rem_i - mb_ext) : rem_i;
    // rem_sel is always below the divisor, so the shift never loses a set bit.
    rem_o   = rem_sel << 1;
  end

endmodule

// File: rtl/float_divider_seq.sv
// Iterative IEEE-754 single divider (Start/Busy/Done), ITERS_PER_CYCLE quotient bits per clock.
// Optional zero/overflow/underflow resolution when FDIV_SPECIAL_CASES_EN is defined.
module float_divider_seq
  import fdiv_pkg::*;
#(
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result
);

  if (!(ITERS_PER_CYCLE == 1 || ITERS_PER_CYCLE == 5 || ITERS_PER_CYCLE == 25)) begin : g_bad_iters
    $error("ITERS_PER_CYCLE must be 1, 5 or 25");
  end

  localparam int         STEPS    = QUOT_W / ITERS_PER_CYCLE;
  localparam logic [4:0] CNT_LAST = 5'(STEPS - 1);

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic signed [9:0]   expd_q, expd_d;
  logic [MANT_W:0]     mb_q, mb_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [QUOT_W-1:0]   quo_q, quo_d;
  logic [31:0]         result_q, result_d;
`ifdef FDIV_SPECIAL_CASES_EN
  logic                a_zero_q, a_zero_d;
  logic                b_zero_q, b_zero_d;
`endif

  logic [REM_W-1:0]           rem_chain [ITERS_PER_CYCLE+1];
  logic [ITERS_PER_CYCLE-1:0] qbits;

  assign rem_chain[0] = rem_q;

  // First step of the cycle lands in the most significant new quotient bit.
  for (genvar k = 0; k < ITERS_PER_CYCLE; k++) begin : g_step
    fdiv_restoring_step u_step (
      .rem_i  (rem_chain[k]),
      .mb_i   (mb_q),
      .qbit_o (qbits[ITERS_PER_CYCLE-1-k]),
      .rem_o  (rem_chain[k+1])
    );
  end

  logic [MANT_W-1:0]  mant;
  logic               sticky;
  logic signed [9:0]  exp_n;
  logic [31:0]        raw_res;
  logic [31:0]        norm_res;

  always_comb begin
    if (quo_q[QUOT_W-1]) begin
      mant   = quo_q[QUOT_W-2:1];
      sticky = quo_q[0] | (|rem_q);
      exp_n  = expd_q + $signed(10'(EXP_BIAS));
    end else begin
      mant   = quo_q[MANT_W-1:0];
      sticky = |rem_q;
      exp_n  = expd_q + $signed(10'(EXP_BIAS - 1));
    end
    raw_res  = {sign_q, exp_n[7:0], mant[MANT_W-1:1], mant[0] | sticky};
    norm_res = raw_res;
`ifdef FDIV_SPECIAL_CASES_EN
    if (b_zero_q && !a_zero_q) begin
      norm_res = {sign_q, 8'hFF, 23'h0};
    end else if (a_zero_q && b_zero_q) begin
      norm_res = 32'h7FC0_0000;
    end else if (a_zero_q) begin
      norm_res = {sign_q, 31'h0};
    end else if (exp_n >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'h0};
    end else if (exp_n <= 10'sd0) begin
      norm_res = {sign_q, 31'h0};
    end
`else
    norm_res = raw_res;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    expd_d   = expd_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
`ifdef FDIV_SPECIAL_CASES_EN
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = DIVIDE;
          cnt_d   = '0;
          sign_d  = Dividend[31] ^ Divisor[31];
          expd_d  = $signed({2'b00, Dividend[30:23]}) - $signed({2'b00, Divisor[30:23]});
          mb_d    = {1'b1, Divisor[MANT_W-1:0]};
          rem_d   = {2'b01, Dividend[MANT_W-1:0]};
          quo_d   = '0;
`ifdef FDIV_SPECIAL_CASES_EN
          a_zero_d = (Dividend[30:23] == 8'h00);
          b_zero_d = (Divisor[30:23] == 8'h00);
`endif
        end
      end
      DIVIDE: begin
        rem_d = rem_chain[ITERS_PER_CYCLE];
        quo_d = (quo_q << ITERS_PER_CYCLE) | QUOT_W'(qbits);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = NORM;
        end
      end
      NORM: begin
        result_d = norm_res;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      expd_q   <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
`ifdef FDIV_SPECIAL_CASES_EN
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      expd_q   <= expd_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
`ifdef FDIV_SPECIAL_CASES_EN
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
`endif
    end
  end

  assign Busy   = (state_q == DIVIDE) || (state_q == NORM);
  assign Done   = (state_q == DONE);
  assign Result = result_q;

endmodule

// File: tb/tb_float_divider_seq.sv
// Directed bench for float_divider_seq: one-bit and five-bit-per-cycle instances
// sharing operands, with separate Start lines.
module tb_float_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start5;
  logic [31:0] dividend, divisor;
  logic        busy1, done1, busy5, done5;
  logic [31:0] result1, result5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_divider_seq #(.ITERS_PER_CYCLE(1)) dut (
    .Clk(clk), .Rst(rst), .Start(start1), .Dividend(dividend), .Divisor(divisor),
    .Busy(busy1), .Done(done1), .Result(result1)
  );

  float_divider_seq #(.ITERS_PER_CYCLE(5)) dut5 (
    .Clk(clk), .Rst(rst), .Start(start5), .Dividend(dividend), .Divisor(divisor),
    .Busy(busy5), .Done(done5), .Result(result5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation and observes 32 cycles after acceptance; an optional
  // extra Start with other operands is pulsed at cycle pulse_at.
  task automatic run_op(input bit use5, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int pulse_at,
                        output int done_cyc, output int done_cnt, output bit busy_ok,
                        output logic [31:0] res_done, output logic [31:0] res_end);
    done_cyc = -1;
    done_cnt = 0;
    busy_ok  = 1'b1;
    res_done = 32'hxxxx_xxxx;
    res_end  = 32'hxxxx_xxxx;
    dividend = a;
    divisor  = b;
    if (use5) start5 = 1'b1; else start1 = 1'b1;
    tick();
    start1   = 1'b0;
    start5   = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h1234_5678;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      if (cyc == pulse_at) begin
        dividend = 32'h3F80_0000;
        divisor  = 32'h4040_0000;
        if (use5) start5 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0;
        start5 = 1'b0;
      end
      if ((use5 ? busy5 : busy1) !== (cyc < lat)) busy_ok = 1'b0;
      if ((use5 ? done5 : done1) === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res_done = use5 ? result5 : result1;
        end
      end
      if (cyc == 32) res_end = use5 ? result5 : result1;
      tick();
    end
    start1 = 1'b0;
    start5 = 1'b0;
  endtask

  initial begin
    int          dc, dn;
    bit          bok;
    logic [31:0] rd, re;
    int          late_done;

    rst = 1'b1; start1 = 1'b0; start5 = 1'b0;
    dividend = 32'h0; divisor = 32'h0;
    tick(); tick();
    check("reset_busy", {31'h0, busy1}, 32'h0);
    check("reset_done", {31'h0, done1}, 32'h0);
    check("reset_result", result1, 32'h0);
    check("reset_result5", result5, 32'h0);
    rst = 1'b0;
    tick();

    // 6.0 / 2.0
    run_op(1'b0, 32'h40C0_0000, 32'h4000_0000, 27, 0, dc, dn, bok, rd, re);
    check("6div2_result", rd, 32'h4040_0000);
    check("6div2_done_cycle", dc, 27);
    check("6div2_done_count", dn, 1);
    check("6div2_busy_window", {31'h0, bok}, 32'h1);
    check("6div2_result_held", re, 32'h4040_0000);

    // 1.0 / 3.0 at one and five bits per cycle
    run_op(1'b0, 32'h3F80_0000, 32'h4040_0000, 27, 0, dc, dn, bok, rd, re);
    check("1div3_result", rd, 32'h3EAA_AAAB);
    check("1div3_done_cycle", dc, 27);
    run_op(1'b1, 32'h3F80_0000, 32'h4040_0000, 7, 0, dc, dn, bok, rd, re);
    check("1div3_x5_result", rd, 32'h3EAA_AAAB);
    check("1div3_x5_done_cycle", dc, 7);
    check("1div3_x5_busy_window", {31'h0, bok}, 32'h1);

    // -7.5 / 2.5 and 1.5 / 1.75
    run_op(1'b0, 32'hC0F0_0000, 32'h4020_0000, 27, 0, dc, dn, bok, rd, re);
    check("neg7p5div2p5_result", rd, 32'hC040_0000);
    run_op(1'b0, 32'h3FC0_0000, 32'h3FE0_0000, 27, 0, dc, dn, bok, rd, re);
    check("1p5div1p75_result", rd, 32'h3F5B_6DB7);

    // Start during Busy must be ignored
    run_op(1'b0, 32'h40C0_0000, 32'h4000_0000, 27, 10, dc, dn, bok, rd, re);
    check("ignored_start_result", rd, 32'h4040_0000);
    check("ignored_start_done_count", dn, 1);
    check("ignored_start_busy_window", {31'h0, bok}, 32'h1);
    check("ignored_start_result_held", re, 32'h4040_0000);

    // Zero and overflow operands
    run_op(1'b1, 32'h3F80_0000, 32'h0000_0000, 7, 0, dc, dn, bok, rd, re);
`ifdef FDIV_SPECIAL_CASES_EN
    check("1div0_result", rd, 32'h7F80_0000);
`else
    check("1div0_result", rd, 32'h7F00_0000);
`endif
    run_op(1'b1, 32'h0000_0000, 32'h0000_0000, 7, 0, dc, dn, bok, rd, re);
`ifdef FDIV_SPECIAL_CASES_EN
    check("0div0_result", rd, 32'h7FC0_0000);
`else
    check("0div0_result", rd, 32'h3F80_0000);
`endif
    run_op(1'b1, 32'h7F00_0000, 32'h0080_0000, 7, 0, dc, dn, bok, rd, re);
`ifdef FDIV_SPECIAL_CASES_EN
    check("overflow_result", rd, 32'h7F80_0000);
`else
    check("overflow_result", rd, 32'h3E00_0000);
`endif

    // Reset in cycle 15 of an operation aborts it
    dividend = 32'h40C0_0000;
    divisor  = 32'h4000_0000;
    start1   = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (14) tick();
    check("pre_reset_busy", {31'h0, busy1}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'h0, busy1}, 32'h0);
    check("abort_done", {31'h0, done1}, 32'h0);
    check("abort_result", result1, 32'h0);
    late_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done1 === 1'b1) late_done++;
      tick();
    end
    check("abort_no_done", late_done, 0);

    // Start held high restarts in the first IDLE cycle after DONE
    dividend = 32'h40C0_0000;
    divisor  = 32'h4000_0000;
    start5   = 1'b1;
    tick();
    repeat (6) tick();
    check("held_done_cycle7", {31'h0, done5}, 32'h1);
    check("held_result", result5, 32'h4040_0000);
    tick();
    check("held_idle_cycle8", {31'h0, busy5}, 32'h0);
    tick();
    check("held_restart_busy", {31'h0, busy5}, 32'h1);
    start5 = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_divider_seq.md
Name: float_divider_seq

Overview:
- Iterative IEEE-754 single-precision divider; the inverse operation of the team's combinational float multiplier.
- Uses the same format conventions as the multiplier:
  - implicit leading 1;
  - no denormals;
  - truncation, with inexact bits OR-jammed into the result LSB.
- Uses a restoring radix-2 mantissa divider with a Start/Busy/Done handshake.
- Sits beside the multiplier in the FPU datapath; its Result feeds the same writeback mux.

Parameters:
- ITERS_PER_CYCLE, default 1: quotient bits resolved per clock. Legal values are 1, 5 and 25 (each divides 25); any other value is an elaboration error.

Ports:
- Clk  in  1  single clock, rising-edge.
- Rst  in  1  reset, synchronous and active-high.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Dividend  in  32  IEEE-754 single numerator; captured on accepted Start.
- Divisor  in  32  IEEE-754 single denominator; captured on accepted Start.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse; Result is valid from this cycle.
- Result  out  32  quotient; held until the next Done.

Behaviour:
- Reset: Rst high at a rising edge forces:
  - state to IDLE;
  - Busy=0, Done=0, Result=32'h0;
  - all internal operand and remainder registers to 0.
- Reset mid-operation: Rst asserted in any state aborts the operation. No Done is produced for the aborted operation.
- States and transitions:
  - IDLE -> DIVIDE on Start. Captures SA^SB, the exponent difference, MA={1,Dividend[22:0]} and MB={1,Divisor[22:0]}. Clears the quotient Q[24:0]. Sets rem=MA.
  - DIVIDE: each step compares rem with MB. If rem>=MB: q bit=1 and rem=rem-MB. In either case rem then shifts left by 1. After 25 steps (25/ITERS_PER_CYCLE cycles): DIVIDE -> NORM.
  - NORM (1 cycle):
    - If Q[24]=1: mant=Q[23:1]; sticky=Q[0]|(rem!=0); exp=EA-EB+127.
    - Else: mant=Q[22:0]; sticky=(rem!=0); exp=EA-EB+126.
    - Exp arithmetic is 10-bit signed internally; bits [7:0] are taken (wrap) unless the optional feature is enabled.
    - Result = {SA^SB, exp[7:0], mant[22:1], mant[0]|sticky}.
    - NORM -> DONE.
  - DONE: Done=1 and Busy=0 for exactly one cycle, then -> IDLE.
- Latency: with Start accepted at edge 0, Done is high in cycle 25/ITERS_PER_CYCLE+2. Default (ITERS_PER_CYCLE=1) gives cycle 27.
- Start outside IDLE (Busy high, or in the DONE cycle) is ignored, not queued.
- Start held high continuously restarts in the first IDLE cycle after DONE.
- Dividend and Divisor may change freely after capture without affecting the operation in flight.
- Sign: always SA^SB, including zero results.

Optional Feature:
- Macro: FDIV_SPECIAL_CASES_EN.
- When defined, NORM resolves operands with exponent field 0 as zero, in this priority order:
  - divisor zero, dividend nonzero -> {sign,8'hFF,23'h0} (Inf);
  - both zero -> 32'h7FC00000 (NaN);
  - dividend zero -> {sign,31'h0};
  - exp>=255 -> Inf;
  - exp<=0 -> signed zero.
- Latency is unchanged; the DIVIDE cycles still run.
- When undefined: raw arithmetic, the exponent wraps mod 256, and zero operands are treated as 1.m×2^(e-127).

Decomposition:
- Package fdiv_pkg holds:
  - state enum {IDLE, DIVIDE, NORM, DONE};
  - EXP_BIAS=127, MANT_W=23, QUOT_W=25.
- Sub-module fdiv_restoring_step: combinational single-bit step. Inputs rem[24:0] and MB[23:0]; outputs qbit and next rem. The top instantiates it ITERS_PER_CYCLE times in a chain.

Test Plan:
- 6.0/2.0: 0x40C00000 / 0x40000000 -> Result 0x40400000. Done a single-cycle pulse at cycle 27; Busy high in cycles 1-26.
- 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (nonzero remainder jams LSB). Same operands with ITERS_PER_CYCLE=5 -> identical Result at cycle 7.
- -7.5/2.5: 0xC0F00000 / 0x40200000 -> 0xC0400000 (Q[24]=1 path).
- 1.5/1.75: 0x3FC00000 / 0x3FE00000 -> 0x3F5B6DB7 (Q[24]=0 path, exp-1, sticky).
- Start pulsed at cycle 10 during 6.0/2.0 with other operands -> ignored; Result still 0x40400000, one Done only. Rst at cycle 15 of a new op -> Busy=0, Done=0, Result=0 next cycle, no Done afterwards.
- With FDIV_SPECIAL_CASES_EN:
  - 1.0/0.0 (0x3F800000/0x00000000) -> 0x7F800000;
  - 0.0/0.0 -> 0x7FC00000;
  - 0x7F000000/0x00800000 -> 0x7F800000.
- Without FDIV_SPECIAL_CASES_EN: 1.0/0.0 -> 0x7F000000 (zero divisor treated as 2^-127).
